// File: rtl/anim_pkg.sv
// Shared types for the animation controller: FSM states, ALU op and operand select codes.
// ANIM_FRAME_PACE_EN adds the PACE state used for frame pacing after each result.
package anim_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StLoadC,
    StLoadX,
    StCyc0,
    StCyc1,
    StCyc2,
    StCyc3,
    StCyc4,
    StDone
`ifdef ANIM_FRAME_PACE_EN
    , StPace
`endif
  } state_e;

  typedef enum logic {
    AluAdd = 1'b0,
    AluMul = 1'b1
  } alu_op_e;

  typedef enum logic [1:0] {
    SelA = 2'd0,
    SelB = 2'd1,
    SelC = 2'd2,
    SelX = 2'd3
  } alu_sel_e;

endpackage

// File: rtl/animation_control_if.sv
// Controller <-> environment signals: start/busy/done, operand handshake and datapath controls.
// master is the controller side, slave is the requester plus datapath.
interface animation_control_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       in_valid;
  logic       in_ready;
  logic       ld_a;
  logic       ld_b;
  logic       ld_c;
  logic       ld_x;
  logic       ld_alu_out;
  logic       ld_r;
  logic [1:0] alu_select_1;
  logic [1:0] alu_select_2;
  logic       alu_op;

  modport master (
    input  start, in_valid,
    output busy, done, in_ready, ld_a, ld_b, ld_c, ld_x, ld_alu_out, ld_r,
           alu_select_1, alu_select_2, alu_op
  );

  modport slave (
    output start, in_valid,
    input  busy, done, in_ready, ld_a, ld_b, ld_c, ld_x, ld_alu_out, ld_r,
           alu_select_1, alu_select_2, alu_op
  );
endinterface

// File: rtl/anim_pace_counter.sv
// Frame pacing down-counter: loaded with Cycles, counts while enabled, pulses expire on
// the last counted cycle. Only used when ANIM_FRAME_PACE_EN is defined.
module anim_pace_counter #(
  parameter int unsigned Cycles = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expire
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= 16'(Cycles);
    end else if (en && (cnt_q != 16'd0)) begin
      cnt_q <= cnt_q - 16'd1;
    end
  end

  assign expire = en && (cnt_q == 16'd1);

endmodule

// File: rtl/animation_control.sv
// Sequencer for r = A*x*x + B*x + C on an external 8-bit datapath: loads four operands,
// runs five ALU steps, pulses done. ANIM_FRAME_PACE_EN inserts FRAME_CYCLES busy cycles after done.
module animation_control
  import anim_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = 16
) (
  input logic                 clk,
  input logic                 reset,
  animation_control_if.master ctrl
);

  if ((FRAME_CYCLES < 1) || (FRAME_CYCLES > 65535)) begin : g_bad_frame_cycles
    $error("FRAME_CYCLES must be in 1..65535");
  end

  state_e state_q, state_d;

`ifdef ANIM_FRAME_PACE_EN
  logic pace_expire;

  anim_pace_counter #(
    .Cycles(FRAME_CYCLES)
  ) u_pace (
    .clk   (clk),
    .reset (reset),
    .load  (state_q == StDone),
    .en    (state_q == StPace),
    .expire(pace_expire)
  );
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    ctrl.busy         = 1'b1;
    ctrl.done         = 1'b0;
    ctrl.in_ready     = 1'b0;
    ctrl.ld_a         = 1'b0;
    ctrl.ld_b         = 1'b0;
    ctrl.ld_c         = 1'b0;
    ctrl.ld_x         = 1'b0;
    ctrl.ld_alu_out   = 1'b0;
    ctrl.ld_r         = 1'b0;
    ctrl.alu_select_1 = SelA;
    ctrl.alu_select_2 = SelA;
    ctrl.alu_op       = AluAdd;

    unique case (state_q)
      StIdle: begin
        ctrl.busy = 1'b0;
        if (ctrl.start) state_d = StLoadA;
      end
      // Load enables follow in_valid directly, so a transfer and its load share a cycle.
      StLoadA: begin
        ctrl.in_ready = 1'b1;
        ctrl.ld_a     = ctrl.in_valid;
        if (ctrl.in_valid) state_d = StLoadB;
      end
      StLoadB: begin
        ctrl.in_ready = 1'b1;
        ctrl.ld_b     = ctrl.in_valid;
        if (ctrl.in_valid) state_d = StLoadC;
      end
      StLoadC: begin
        ctrl.in_ready = 1'b1;
        ctrl.ld_c     = ctrl.in_valid;
        if (ctrl.in_valid) state_d = StLoadX;
      end
      StLoadX: begin
        ctrl.in_ready = 1'b1;
        ctrl.ld_x     = ctrl.in_valid;
        if (ctrl.in_valid) state_d = StCyc0;
      end
      StCyc0, StCyc1: begin
        ctrl.ld_a         = 1'b1;
        ctrl.ld_alu_out   = 1'b1;
        ctrl.alu_select_1 = SelA;
        ctrl.alu_select_2 = SelX;
        ctrl.alu_op       = AluMul;
        state_d           = (state_q == StCyc0) ? StCyc1 : StCyc2;
      end
      StCyc2: begin
        ctrl.ld_b         = 1'b1;
        ctrl.ld_alu_out   = 1'b1;
        ctrl.alu_select_1 = SelB;
        ctrl.alu_select_2 = SelX;
        ctrl.alu_op       = AluMul;
        state_d           = StCyc3;
      end
      StCyc3: begin
        ctrl.ld_a         = 1'b1;
        ctrl.ld_alu_out   = 1'b1;
        ctrl.alu_select_1 = SelA;
        ctrl.alu_select_2 = SelB;
        state_d           = StCyc4;
      end
      StCyc4: begin
        ctrl.ld_r         = 1'b1;
        ctrl.alu_select_1 = SelA;
        ctrl.alu_select_2 = SelC;
        state_d           = StDone;
      end
      StDone: begin
        ctrl.done = 1'b1;
`ifdef ANIM_FRAME_PACE_EN
        state_d   = StPace;
`else
        state_d   = StIdle;
`endif
      end
`ifdef ANIM_FRAME_PACE_EN
      StPace: begin
        if (pace_expire) state_d = StIdle;
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_animation_control.sv
// Bench for animation_control paired with a behavioural 8-bit datapath; a timeline model
// of the controller is compared against every output on every falling edge.
module tb_animation_control;

  localparam int unsigned FrameCycles = 4;
`ifdef ANIM_FRAME_PACE_EN
  localparam int PaceCycles = FrameCycles;
`else
  localparam int PaceCycles = 0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  animation_control_if bus ();

  animation_control #(
    .FRAME_CYCLES(FrameCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ctrl (bus)
  );

  always #5 clk = ~clk;

  // Datapath: operand registers, result register and a two-input add/multiply ALU.
  logic [7:0] data_in = 8'h00;
  logic [7:0] ra, rb, rc, rx, rr, in1, in2, alu_out;

  always_comb begin
    case (bus.alu_select_1)
      2'd0:    in1 = ra;
      2'd1:    in1 = rb;
      2'd2:    in1 = rc;
      default: in1 = rx;
    endcase
    case (bus.alu_select_2)
      2'd0:    in2 = ra;
      2'd1:    in2 = rb;
      2'd2:    in2 = rc;
      default: in2 = rx;
    endcase
    alu_out = bus.alu_op ? (in1 * in2) : (in1 + in2);
  end

  always @(posedge clk) begin
    if (bus.ld_a) ra <= bus.ld_alu_out ? alu_out : data_in;
    if (bus.ld_b) rb <= bus.ld_alu_out ? alu_out : data_in;
    if (bus.ld_c) rc <= bus.ld_alu_out ? alu_out : data_in;
    if (bus.ld_x) rx <= bus.ld_alu_out ? alu_out : data_in;
    if (bus.ld_r) rr <= alu_out;
  end

  // Timeline model: run in progress, operands taken so far, cycles since X, pacing left.
  bit m_run = 1'b0;
  int m_nacc = 0;
  int m_post = 0;
  int m_pace = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_run  <= 1'b0;
      m_nacc <= 0;
      m_post <= 0;
      m_pace <= 0;
    end else if (m_pace > 0) begin
      m_pace <= m_pace - 1;
    end else if (!m_run) begin
      if (bus.start) begin
        m_run  <= 1'b1;
        m_nacc <= 0;
        m_post <= 0;
      end
    end else if (m_nacc < 4) begin
      if (bus.in_valid) m_nacc <= m_nacc + 1;
    end else if (m_post == 5) begin
      m_run  <= 1'b0;
      m_pace <= PaceCycles;
    end else begin
      m_post <= m_post + 1;
    end
  end

  always @(negedge clk) begin : cmp
    logic [3:0]  e_ld;
    logic        e_busy, e_rdy, e_done, e_alu, e_r, e_op;
    logic [1:0]  e_s1, e_s2;
    logic [13:0] exp_v, act_v;
    e_ld = 4'b0; e_busy = 1'b0; e_rdy = 1'b0; e_done = 1'b0;
    e_alu = 1'b0; e_r = 1'b0; e_op = 1'b0; e_s1 = 2'd0; e_s2 = 2'd0;
    if (!reset) begin
      e_busy = m_run || (m_pace > 0);
      if (m_run && (m_nacc < 4)) begin
        e_rdy = 1'b1;
        e_ld  = bus.in_valid ? (4'b1000 >> m_nacc) : 4'b0000;
      end else if (m_run) begin
        case (m_post)
          0, 1: begin e_ld = 4'b1000; e_alu = 1'b1; e_s1 = 2'd0; e_s2 = 2'd3; e_op = 1'b1; end
          2:    begin e_ld = 4'b0100; e_alu = 1'b1; e_s1 = 2'd1; e_s2 = 2'd3; e_op = 1'b1; end
          3:    begin e_ld = 4'b1000; e_alu = 1'b1; e_s1 = 2'd0; e_s2 = 2'd1; end
          4:    begin e_r = 1'b1; e_s1 = 2'd0; e_s2 = 2'd2; end
          default: e_done = 1'b1;
        endcase
      end
    end
    exp_v = {e_busy, e_rdy, e_done, e_ld, e_alu, e_r, e_s1, e_s2, e_op};
    act_v = {bus.busy, bus.in_ready, bus.done, bus.ld_a, bus.ld_b, bus.ld_c, bus.ld_x,
             bus.ld_alu_out, bus.ld_r, bus.alu_select_1, bus.alu_select_2, bus.alu_op};
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL ctrl_outputs t=%0t actual=%b required=%b", $time, act_v, exp_v);
    end
  end

  function automatic int model_result(int a, int b, int c, int x);
    return (a * x * x + b * x + c) % 256;
  endfunction

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, req);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && (n < 50));
    check("in_ready_wait", int'(bus.in_ready), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && (n < 40));
    check("idle_wait", int'(bus.busy), 0);
  endtask

  // Offers one operand, preceded by g load cycles with in_valid low.
  task automatic xfer(input logic [7:0] d, input int g);
    bus.in_valid = 1'b0;
    data_in      = 8'hEE;
    for (int i = 0; i < g; i++) begin
      wait_ready();
      @(posedge clk);
      #2;
    end
    bus.in_valid = 1'b1;
    data_in      = d;
    wait_ready();
    @(posedge clk);
    #2;
  endtask

  task automatic run_start(input int a, input int b, input int c, input int x, input int g,
                           input bit hold);
    bus.start = 1'b1;
    @(posedge clk);
    #2;
    bus.start = hold;
    xfer(8'(a), g);
    xfer(8'(b), g);
    xfer(8'(c), g);
    xfer(8'(x), g);
    bus.in_valid = 1'b0;
  endtask

  // Counting the X accept edge as the first, done must show after the sixth edge.
  task automatic run_finish(input int a, input int b, input int c, input int x, input int lit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && (n < 20));
    check("done_latency", n, 6);
    check("result_literal", int'(rr), lit);
    check("result_model", int'(rr), model_result(a, b, c, x));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1);
  end

  initial begin : main
    int n;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    reset        = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    // First start right after reset release, in_valid high throughout the loads.
    run_start(2, 3, 4, 5, 0, 1'b0);
    run_finish(2, 3, 4, 5, 69);

    wait_idle();
    run_start(10, 0, 0, 10, 0, 1'b0);
    run_finish(10, 0, 0, 10, 232);

    wait_idle();
    run_start(7, 1, 9, 3, 3, 1'b0);
    run_finish(7, 1, 9, 3, 75);

    // Reset while the controller is in CYC_2.
    wait_idle();
    run_start(2, 3, 4, 5, 0, 1'b0);
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("reset_mid_busy", int'(bus.busy), 0);
    check("reset_mid_done", int'(bus.done), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) n++;
    end
    check("no_done_after_reset", n, 0);
    wait_idle();
    run_start(2, 3, 4, 5, 0, 1'b0);
    run_finish(2, 3, 4, 5, 69);

    // start held across two runs: gap from done to the next LOAD_A.
    wait_idle();
    run_start(1, 2, 3, 4, 0, 1'b1);
    run_finish(1, 2, 3, 4, 27);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && (n < 30));
    check("restart_gap", n, PaceCycles + 2);
    run_start(3, 4, 5, 6, 0, 1'b1);
    run_finish(3, 4, 5, 6, 137);
    bus.start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
